// File: rtl/instr_sequencer.sv
// Micro-sequencer that steps an 8-bit instruction through fetch, decode and
// per-class execute states; outputs are all registered.
module instr_sequencer #(
    parameter int CYCLE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         instruction,
    input  logic               flag_zero,
    input  logic               flag_carry,
    output logic [7:0]         state,
    output logic [CYCLE_W-1:0] cycle,
    output logic [3:0]         opcode,
    output logic               halted
);

    typedef enum logic [7:0] {
        FETCH_ADDR = 8'h01,
        FETCH_INST = 8'h02,
        DECODE     = 8'h03,
        ALU_EXEC   = 8'h10,
        ALU_STORE  = 8'h11,
        IMM_ADDR   = 8'h20,
        SET_REG    = 8'h21,
        JMP_ADDR   = 8'h30,
        JMP_LOAD   = 8'h31,
        SKIP       = 8'h32,
        HALT       = 8'hFE,
        NEXT       = 8'hFF
    } state_t;

    state_t cur;
    state_t nxt;

    // Flags and the live opcode only influence the path out of DECODE.
    function automatic state_t next_state(input state_t s, input logic [3:0] op,
                                          input logic fz, input logic fc);
        state_t n;
        n = FETCH_ADDR;
        case (s)
            FETCH_ADDR: n = FETCH_INST;
            FETCH_INST: n = DECODE;
            DECODE: begin
                case (op)
                    4'h1:                      n = IMM_ADDR;
                    4'h2:                      n = JMP_ADDR;
                    4'h3:                      n = fz ? JMP_ADDR : SKIP;
                    4'h8:                      n = fc ? JMP_ADDR : SKIP;
                    4'h4, 4'h5, 4'h6, 4'h7:    n = ALU_EXEC;
                    4'hF:                      n = HALT;
                    default:                   n = NEXT;
                endcase
            end
            ALU_EXEC:  n = ALU_STORE;
            ALU_STORE: n = NEXT;
            IMM_ADDR:  n = SET_REG;
            SET_REG:   n = NEXT;
            JMP_ADDR:  n = JMP_LOAD;
            JMP_LOAD:  n = NEXT;
            SKIP:      n = NEXT;
            HALT:      n = HALT;
            NEXT:      n = FETCH_ADDR;
            default:   n = FETCH_ADDR;
        endcase
        return n;
    endfunction

    assign nxt   = next_state(cur, instruction[7:4], flag_zero, flag_carry);
    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur    <= FETCH_ADDR;
            cycle  <= '0;
            opcode <= 4'h0;
            halted <= 1'b0;
        end else begin
            cur    <= nxt;
            halted <= (nxt == HALT);
            if (nxt == FETCH_ADDR)
                cycle <= '0;
            else if (cycle != '1)
                cycle <= cycle + 1'b1;
            if (cur == DECODE)
                opcode <= instruction[7:4];
        end
    end

endmodule
